hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting the width of the performance counters.
REQ-002 SHALL have parameter TIMEOUT, default 16, setting the memory-wait cycle limit before mem_err is raised.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have ports Rs1_D and Rs2_D, input, 5 each, the source registers of the instruction in Decode.
REQ-006 SHALL have ports Rs1_E, Rs2_E and Rd_E, input, 5 each, the source and destination registers in Execute.
REQ-007 SHALL have ports Rd_M and Rd_W, input, 5 each, the destination registers in Memory and Writeback.
REQ-008 SHALL have ports RegWrite_M and RegWrite_W, input, 1 each, the register-write enables in Memory and Writeback.
REQ-009 SHALL have port ResultSrc_E, input, 2; value 2'b01 marks a load in Execute.
REQ-010 SHALL have port PCSrc_E, input, 1, indicating a taken branch or jump resolved in Execute.
REQ-011 SHALL have port mem_req_M, input, 1, indicating a data-memory access in Memory.
REQ-012 SHALL have port mem_ready, input, 1, indicating data-memory completion this cycle.
REQ-013 SHALL have ports Stall_F, Stall_D, Stall_E and Stall_M, output, 1 each, the hold enables for the pipeline registers.
REQ-014 SHALL have ports Flush_D, Flush_E and Flush_W, output, 1 each, which bubble the named stage register.
REQ-015 SHALL have ports ForwardA_E and ForwardB_E, output, 2 each: 00 selects the register file, 01 selects W, 10 selects M.
REQ-016 SHALL have port mem_err, output, 1, a sticky memory-timeout flag.
REQ-017 SHALL have ports stall_cycles and flush_count, output, WIDTH each, the performance counters.

Function
REQ-018 SHALL define mwait = mem_req_M & !mem_ready, combinationally.
REQ-019 SHALL, while mwait=1, assert Stall_F, Stall_D, Stall_E, Stall_M and Flush_W, and force Flush_D=Flush_E=0 (freeze has highest priority).
REQ-020 SHALL define lu = (ResultSrc_E==2'b01) & (Rd_E!=0) & (Rd_E==Rs1_D | Rd_E==Rs2_D).
REQ-021 SHALL, when mwait=0 and PCSrc_E=1, assert Flush_D=Flush_E=1 with all stalls 0; a concurrent lu is ignored.
REQ-022 SHALL, when mwait=0, PCSrc_E=0 and lu=1, assert Stall_F=Stall_D=Flush_E=1 for that cycle only.
REQ-023 SHALL otherwise drive all stall and flush outputs to 0.
REQ-024 SHALL assert a PCSrc_E held during a freeze as a flush on the first cycle after the freeze ends (no state needed, because E is held).
REQ-025 SHALL set ForwardA_E=10 if RegWrite_M & Rd_M!=0 & Rd_M==Rs1_E; else 01 if RegWrite_W & Rd_W!=0 & Rd_W==Rs1_E; else 00.
REQ-026 SHALL derive ForwardB_E by the same rule using Rs2_E; M has priority over W.
REQ-027 SHALL implement an FSM with states RUN and WAIT: RUN->WAIT when mwait=1; WAIT->RUN when mwait=0; RUN otherwise stays.
REQ-028 SHALL hold a wait counter that is cleared on entry to RUN and increments by 1 each cycle in WAIT while mwait=1, saturating at TIMEOUT.
REQ-029 SHALL set mem_err=1 on the edge where the wait counter reaches TIMEOUT, and hold it until reset; the pipeline keeps waiting.
REQ-030 SHALL increment stall_cycles by 1 on each cycle where any Stall_* =1, saturating at all-ones.
REQ-031 SHALL increment flush_count by 1 on each cycle where Flush_D | Flush_E =1, saturating at all-ones.
REQ-032 SHALL keep every stall, flush and forward output combinational with zero latency; only the FSM, wait counter, mem_err and performance counters are registered.

Reset
REQ-033 SHALL, while rst_n=0, immediately set the FSM to RUN and clear the wait counter, mem_err, stall_cycles and flush_count to 0, independent of clk.
REQ-034 SHALL, on reset assertion mid-WAIT, abandon the wait; combinational outputs continue to follow their inputs.

Verification
REQ-035 SHALL be verified with a load-use case: ResultSrc_E=01, Rd_E=5, Rs1_D=5 -> Stall_F=Stall_D=Flush_E=1 for one cycle, stall_cycles +1.
REQ-036 SHALL be verified with a branch during a load-use: PCSrc_E=1 with lu=1 -> Flush_D=Flush_E=1, Stall_F=0, flush_count +1.
REQ-037 SHALL be verified with forwarding priority: Rd_M=Rd_W=Rs1_E=3, both RegWrite=1 -> ForwardA_E=10; then Rd_M=0 -> 01; then Rs1_E=0 -> 00.
REQ-038 SHALL be verified with a 3-cycle memory wait plus branch: mwait=1 for 3 cycles with PCSrc_E=1 -> all stalls and Flush_W=1 for 3 cycles, Flush_D/E=0, then Flush_D=Flush_E=1 on the 4th cycle.
REQ-039 SHALL be verified with a timeout: mwait held 20 cycles at TIMEOUT=16 -> mem_err rises after the 16th WAIT increment and stays 1 after mwait clears.
REQ-040 SHALL be verified with reset during WAIT: rst_n=0 in cycle 5 of a wait -> mem_err=0, counters=0, FSM=RUN with no clock edge required.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline hazard unit for a 5-stage core. Produces stalls,
//             flushes and operand forwarding selects, tracks data-memory
//             waits with a timeout flag, and counts stall/flush cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             mem_err,
    output logic [WIDTH-1:0] stall_cycles,
    output logic [WIDTH-1:0] flush_count
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [WIDTH-1:0]  stall_q, stall_d;
    logic [WIDTH-1:0]  flush_q, flush_d;

    logic mwait;
    logic lu;
    logic any_stall;
    logic any_flush;

    assign mwait = mem_req_M & ~mem_ready;
    assign lu    = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                   ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // Stall/flush priority: memory freeze, then taken branch, then load-use.
    // A branch held in E during a freeze naturally flushes once the freeze lifts.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_W = 1'b0;
        if (mwait) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (lu) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    // Forwarding selects; the younger result in M wins over W.
    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E))
            ForwardA_E = 2'b10;
        else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E))
            ForwardA_E = 2'b01;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E))
            ForwardB_E = 2'b10;
        else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E))
            ForwardB_E = 2'b01;
    end

    // Memory-wait FSM with saturating wait counter and sticky timeout flag.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mwait) state_d = WAIT;
            end
            WAIT: begin
                if (!mwait) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q != TMAX) begin
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == TMAX - CW'(1)) mem_err_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    assign any_stall = Stall_F | Stall_D | Stall_E | Stall_M;
    assign any_flush = Flush_D | Flush_E;

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (any_stall && !(&stall_q)) stall_d = stall_q + WIDTH'(1);
        if (any_flush && !(&flush_q)) flush_d = flush_q + WIDTH'(1);
    end

    // State registers; reset abandons any wait in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule
`default_nettype wire
